// File: rtl/imm_pipe.sv
// Two-stage pipelined immediate generator and branch-target unit for the decode path.
// Stage 1 decodes format and immediate; stage 2 forms pc + imm for the ALU side.
module imm_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     insn_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] target_o
);

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ILL   = 3'd7
  } fmt_t;

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            shift_op;
  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [5:0]      shamt;
  fmt_t            dec_fmt;
  logic [XLEN-1:0] dec_imm;

  logic            s1_valid, s2_valid;
  logic            s1_load, s2_load;
  fmt_t            s1_fmt, s2_fmt;
  logic            s1_illegal, s2_illegal;
  logic [XLEN-1:0] s1_imm, s1_pc;
  logic [XLEN-1:0] s2_imm, s2_target;

  assign opcode   = insn_i[6:0];
  assign funct3   = insn_i[14:12];
  assign shift_op = (funct3 == 3'b001) || (funct3 == 3'b101);

  // 32-bit forms are built first and widened afterwards so one set serves both XLENs.
  assign imm_i = {{20{insn_i[31]}}, insn_i[31:20]};
  assign imm_s = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
  assign imm_b = {{20{insn_i[31]}}, insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
  assign imm_u = {insn_i[31:12], 12'b0};
  assign imm_j = {{12{insn_i[31]}}, insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};

  // Word shifts (0011011) only ever take a 5-bit amount, even on RV64.
  assign shamt = (RV64 && opcode == 7'b0010011) ? insn_i[25:20] : {1'b0, insn_i[24:20]};

  always_comb begin
    dec_fmt = FMT_ILL;
    dec_imm = '0;
    case (opcode)
      7'b0000011, 7'b0001111, 7'b1100111, 7'b1110011: dec_fmt = FMT_I;
      7'b0010011: dec_fmt = shift_op ? FMT_SHAMT : FMT_I;
      7'b0011011: if (RV64) dec_fmt = shift_op ? FMT_SHAMT : FMT_I;
      7'b0100011: dec_fmt = FMT_S;
      7'b1100011: dec_fmt = FMT_B;
      7'b0110111, 7'b0010111: dec_fmt = FMT_U;
      7'b1101111: dec_fmt = FMT_J;
      7'b0110011: dec_fmt = FMT_R;
      7'b0111011: if (RV64) dec_fmt = FMT_R;
      default: dec_fmt = FMT_ILL;
    endcase
    case (dec_fmt)
      FMT_I:     dec_imm = XLEN'($signed(imm_i));
      FMT_S:     dec_imm = XLEN'($signed(imm_s));
      FMT_B:     dec_imm = XLEN'($signed(imm_b));
      FMT_U:     dec_imm = XLEN'($signed(imm_u));
      FMT_J:     dec_imm = XLEN'($signed(imm_j));
      FMT_SHAMT: dec_imm = XLEN'(shamt);
      default:   dec_imm = '0;
    endcase
  end

  // ready_o depends combinationally on ready_i so a full pipe refills the same cycle it drains.
  assign s2_load = !s2_valid || ready_i;
  assign s1_load = !s1_valid || s2_load;
  assign ready_o = s1_load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_load) s1_valid <= valid_i;
      if (s2_load) s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_fmt     <= FMT_R;
      s1_illegal <= 1'b0;
      s1_imm     <= '0;
      s1_pc      <= '0;
      s2_fmt     <= FMT_R;
      s2_illegal <= 1'b0;
      s2_imm     <= '0;
      s2_target  <= '0;
    end else begin
      if (s1_load && valid_i) begin
        s1_fmt     <= dec_fmt;
        s1_illegal <= (dec_fmt == FMT_ILL);
        s1_imm     <= dec_imm;
        s1_pc      <= pc_i;
      end
      if (s2_load && s1_valid) begin
        s2_fmt     <= s1_fmt;
        s2_illegal <= s1_illegal;
        s2_imm     <= s1_imm;
        s2_target  <= s1_pc + s1_imm;
      end
    end
  end

  assign valid_o   = s2_valid;
  assign imm_o     = s2_imm;
  assign fmt_o     = s2_fmt;
  assign illegal_o = s2_illegal;
  assign target_o  = s2_target;

endmodule

// File: tb/tb_imm_pipe.sv
// Self-checking bench for imm_pipe: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed results for XLEN=32 and XLEN=64 instances.
module tb_imm_pipe;

  logic        clk;
  logic        reset_n;
  logic        flush_i, valid_i, ready_i;
  logic [31:0] insn_i, pc_i;
  logic        ready_o, valid_o, illegal_o;
  logic [31:0] imm_o, target_o;
  logic [2:0]  fmt_o;

  logic        w_valid_i;
  logic [31:0] w_insn_i;
  logic [63:0] w_pc_i;
  logic        w_ready_o, w_valid_o, w_illegal_o;
  logic [63:0] w_imm_o, w_target_o;
  logic [2:0]  w_fmt_o;

  int n_checks = 0;
  int n_pass   = 0;
  int out_count = 0;

  imm_pipe #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .insn_i(insn_i), .pc_i(pc_i), .valid_o(valid_o), .ready_i(ready_i), .imm_o(imm_o),
    .fmt_o(fmt_o), .illegal_o(illegal_o), .target_o(target_o)
  );

  imm_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush_i(1'b0), .valid_i(w_valid_i), .ready_o(w_ready_o),
    .insn_i(w_insn_i), .pc_i(w_pc_i), .valid_o(w_valid_o), .ready_i(1'b1), .imm_o(w_imm_o),
    .fmt_o(w_fmt_o), .illegal_o(w_illegal_o), .target_o(w_target_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [2:0]  fmt;
    logic        ill;
    bit          at_out;
  } ent_t;

  ent_t q[$];

  // Reference decode written from the field layout with plain arithmetic on signed integers.
  function automatic ent_t refModel(input logic [31:0] insn, input logic [63:0] pc, input int xlen);
    ent_t        e;
    longint      s;
    logic [63:0] mask;
    bit          sh;
    sh   = (insn[14:12] == 3'd1) || (insn[14:12] == 3'd5);
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    s    = 0;
    case (insn[6:0])
      7'h03, 7'h0F, 7'h67, 7'h73: e.fmt = 3'd1;
      7'h13:        e.fmt = sh ? 3'd6 : 3'd1;
      7'h1B:        e.fmt = (xlen == 64) ? (sh ? 3'd6 : 3'd1) : 3'd7;
      7'h23:        e.fmt = 3'd2;
      7'h63:        e.fmt = 3'd3;
      7'h37, 7'h17: e.fmt = 3'd4;
      7'h6F:        e.fmt = 3'd5;
      7'h33:        e.fmt = 3'd0;
      7'h3B:        e.fmt = (xlen == 64) ? 3'd0 : 3'd7;
      default:      e.fmt = 3'd7;
    endcase
    case (e.fmt)
      3'd1: begin
        s = longint'(insn[31:20]);
        if (insn[31]) s = s - 4096;
      end
      3'd2: begin
        s = longint'(insn[31:25]) * 32 + longint'(insn[11:7]);
        if (insn[31]) s = s - 4096;
      end
      3'd3: begin
        s = longint'(insn[7]) * 2048 + longint'(insn[30:25]) * 32 + longint'(insn[11:8]) * 2;
        if (insn[31]) s = s - 4096;
      end
      3'd4: begin
        s = longint'(insn[31:12]) * 4096;
        if (insn[31]) s = s - 64'sh1_0000_0000;
      end
      3'd5: begin
        s = longint'(insn[19:12]) * 4096 + longint'(insn[20]) * 2048 + longint'(insn[30:21]) * 2;
        if (insn[31]) s = s - 1048576;
      end
      3'd6: s = (xlen == 64 && insn[6:0] == 7'h13) ? longint'(insn[25:20]) : longint'(insn[24:20]);
      default: s = 0;
    endcase
    e.ill    = (e.fmt == 3'd7);
    e.imm    = s & mask;
    e.tgt    = (pc + e.imm) & mask;
    e.at_out = 1'b0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                               input logic fl, input logic rdy);
    valid_i = v;
    insn_i  = insn;
    pc_i    = pc;
    flush_i = fl;
    ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  // Occupancy model: at most two entries; the head reaches the output on the edge after capture
  // unless the output slot is still occupied by an unconsumed result.
  bit   model_acc;
  ent_t model_head;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
    end else if (flush_i) begin
      q.delete();
    end else begin
      model_acc = valid_i && ((q.size() < 2) || ready_i);
      if (q.size() > 0 && q[0].at_out && ready_i) void'(q.pop_front());
      if (q.size() > 0 && !q[0].at_out) begin
        model_head = q.pop_front();
        model_head.at_out = 1'b1;
        q.push_front(model_head);
      end
      if (model_acc) q.push_back(refModel(insn_i, {32'b0, pc_i}, 32));
    end
  end

  // Per-cycle comparison against the model, plus a hold check across stalled cycles.
  bit          exp_valid;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_imm, prev_tgt;
  logic [2:0]  prev_fmt;
  logic        prev_ill;
  always @(negedge clk) begin
    exp_valid = (q.size() > 0) && q[0].at_out;
    checkOutput("valid_o", 64'(valid_o), 64'(exp_valid));
    checkOutput("ready_o", 64'(ready_o), 64'((q.size() < 2) || ready_i));
    if (exp_valid && valid_o) begin
      checkOutput("imm_o", 64'(imm_o), q[0].imm);
      checkOutput("fmt_o", 64'(fmt_o), 64'(q[0].fmt));
      checkOutput("illegal_o", 64'(illegal_o), 64'(q[0].ill));
      checkOutput("target_o", 64'(target_o), q[0].tgt);
    end
    if (prev_stall && reset_n) begin
      checkOutput("hold_imm", 64'(imm_o), 64'(prev_imm));
      checkOutput("hold_fmt", 64'(fmt_o), 64'(prev_fmt));
      checkOutput("hold_ill", 64'(illegal_o), 64'(prev_ill));
      checkOutput("hold_tgt", 64'(target_o), 64'(prev_tgt));
    end
    prev_stall = valid_o && !ready_i && !flush_i && reset_n;
    prev_imm   = imm_o;
    prev_fmt   = fmt_o;
    prev_ill   = illegal_o;
    prev_tgt   = target_o;
    if (valid_o && ready_i && !flush_i && reset_n) out_count++;
  end

  logic [31:0] vins[13] = '{32'hFFF00093, 32'h123450B7, 32'hFE000EE3, 32'h0040006F,
                            32'h00309093, 32'h4030D093, 32'h0000007F, 32'h0000009B,
                            32'hFE112C23, 32'h002081B3, 32'h7FF0A083, 32'h8000006F,
                            32'h80000097};
  logic [31:0] vpc[13]  = '{32'h1000, 32'h1004, 32'h1000, 32'h2000, 32'h3000, 32'h3004,
                            32'h3008, 32'h300C, 32'h4000, 32'h4004, 32'h4008, 32'h00200000,
                            32'h10};
  logic [31:0] vimm[13] = '{32'hFFFFFFFF, 32'h12345000, 32'hFFFFFFFC, 32'h4, 32'h3, 32'h3,
                            32'h0, 32'h0, 32'hFFFFFFF8, 32'h0, 32'h7FF, 32'hFFF00000,
                            32'h80000000};
  logic [2:0]  vfmt[13] = '{3'd1, 3'd4, 3'd3, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7, 3'd2, 3'd0,
                            3'd1, 3'd5, 3'd4};
  logic [31:0] vtgt[13] = '{32'h00000FFF, 32'h12346004, 32'h00000FFC, 32'h2004, 32'h3003,
                            32'h3007, 32'h3008, 32'h300C, 32'h3FF8, 32'h4004, 32'h4807,
                            32'h00100000, 32'h80000010};

  logic [31:0] winsn[6] = '{32'h0000009B, 32'h03F09093, 32'h800000B7, 32'h0210109B,
                            32'h0000003B, 32'hFFF00093};
  logic [63:0] wimm[6]  = '{64'h0, 64'd63, 64'hFFFF_FFFF_8000_0000, 64'd1, 64'h0,
                            64'hFFFF_FFFF_FFFF_FFFF};
  logic [2:0]  wfmt[6]  = '{3'd1, 3'd6, 3'd4, 3'd6, 3'd0, 3'd1};
  logic [63:0] wtgt[6]  = '{64'h1_0000_0000, 64'h1_0000_003F, 64'h0_8000_0000,
                            64'h1_0000_0001, 64'h1_0000_0000, 64'h0_FFFF_FFFF};

  initial begin
    ent_t e;
    int   idx;
    int   base;
    bit   acc;
    reset_n   = 1'b0;
    w_valid_i = 1'b0;
    w_insn_i  = '0;
    w_pc_i    = '0;

    // Reset state
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("rst_valid", 64'(valid_o), 64'd0);
    checkOutput("rst_imm", 64'(imm_o), 64'd0);
    checkOutput("rst_fmt", 64'(fmt_o), 64'd0);
    checkOutput("rst_ill", 64'(illegal_o), 64'd0);
    checkOutput("rst_tgt", 64'(target_o), 64'd0);
    checkOutput("rst_ready", 64'(ready_o), 64'd1);
    checkOutput("rst_imm64", w_imm_o, 64'd0);
    reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("rel_ready", 64'(ready_o), 64'd1);

    // Directed stream, back-to-back: vector j is visible after the edge that captures vector j+1
    for (int k = 0; k <= 13; k++) begin
      if (k < 13) applyStimulus(1, vins[k], vpc[k], 0, 1);
      else        applyStimulus(0, 0, 0, 0, 1);
      if (k == 0) checkOutput("lat_first_not_yet", 64'(valid_o), 64'd0);
      if (k >= 1) begin
        checkOutput("vec_valid", 64'(valid_o), 64'd1);
        checkOutput("vec_imm", 64'(imm_o), 64'(vimm[k-1]));
        checkOutput("vec_fmt", 64'(fmt_o), 64'(vfmt[k-1]));
        checkOutput("vec_ill", 64'(illegal_o), 64'(vfmt[k-1] == 3'd7));
        checkOutput("vec_tgt", 64'(target_o), 64'(vtgt[k-1]));
        e = refModel(vins[k-1], {32'b0, vpc[k-1]}, 32);
        checkOutput("model_imm", e.imm, 64'(vimm[k-1]));
        checkOutput("model_tgt", e.tgt, 64'(vtgt[k-1]));
      end
    end
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);

    // Back-pressure: six instructions offered continuously, ready_i low for cycles 2..5
    idx  = 0;
    base = out_count;
    for (int c = 0; c < 16; c++) begin
      valid_i = (idx < 6);
      insn_i  = (idx < 6) ? vins[idx] : 32'h0;
      pc_i    = 32'h5000 + 32'(idx) * 4;
      flush_i = 1'b0;
      ready_i = !(c >= 2 && c <= 5);
      #1;
      acc = valid_i && ready_o;
      if (c == 2) checkOutput("bp_ready_low", 64'(ready_o), 64'd0);
      if (c == 5) begin
        checkOutput("bp_hold_valid", 64'(valid_o), 64'd1);
        checkOutput("bp_hold_imm", 64'(imm_o), 64'(vimm[0]));
        checkOutput("bp_hold_tgt", 64'(target_o), 64'h4FFF);
      end
      if (c == 6) checkOutput("bp_ready_rise", 64'(ready_o), 64'd1);
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    checkOutput("bp_accepted", 64'(idx), 64'd6);
    checkOutput("bp_emerged", 64'(out_count - base), 64'd6);

    // Flush with two entries in flight; the instruction offered alongside the flush is dropped
    applyStimulus(1, vins[2], 32'h6000, 0, 1);
    applyStimulus(1, vins[3], 32'h6004, 0, 1);
    checkOutput("fl_pre_valid", 64'(valid_o), 64'd1);
    applyStimulus(1, vins[4], 32'h6008, 1, 1);
    checkOutput("fl_valid", 64'(valid_o), 64'd0);
    applyStimulus(1, vins[8], 32'h7000, 0, 1);
    checkOutput("fl_after_valid", 64'(valid_o), 64'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("fl_next_valid", 64'(valid_o), 64'd1);
    checkOutput("fl_next_imm", 64'(imm_o), 64'hFFFFFFF8);
    checkOutput("fl_next_fmt", 64'(fmt_o), 64'd2);
    checkOutput("fl_next_tgt", 64'(target_o), 64'h6FF8);
    applyStimulus(0, 0, 0, 0, 1);

    // Asynchronous reset mid-stream
    applyStimulus(1, vins[0], 32'h8000, 0, 1);
    applyStimulus(1, vins[1], 32'h8004, 0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("ars_valid", 64'(valid_o), 64'd0);
    checkOutput("ars_imm", 64'(imm_o), 64'd0);
    checkOutput("ars_fmt", 64'(fmt_o), 64'd0);
    checkOutput("ars_tgt", 64'(target_o), 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 0, 0, 1);
    reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("ars_rel_ready", 64'(ready_o), 64'd1);
    checkOutput("ars_rel_valid", 64'(valid_o), 64'd0);
    applyStimulus(1, vins[2], 32'h9000, 0, 1);
    checkOutput("ars_lat1_valid", 64'(valid_o), 64'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("ars_lat2_valid", 64'(valid_o), 64'd1);
    checkOutput("ars_lat2_imm", 64'(imm_o), 64'hFFFFFFFC);
    checkOutput("ars_lat2_tgt", 64'(target_o), 64'h8FFC);
    applyStimulus(0, 0, 0, 0, 1);

    // XLEN=64 instance, one instruction at a time
    for (int i = 0; i < 6; i++) begin
      w_valid_i = 1'b1;
      w_insn_i  = winsn[i];
      w_pc_i    = 64'h1_0000_0000;
      @(posedge clk);
      #1;
      w_valid_i = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("x64_valid", 64'(w_valid_o), 64'd1);
      checkOutput("x64_imm", w_imm_o, wimm[i]);
      checkOutput("x64_fmt", 64'(w_fmt_o), 64'(wfmt[i]));
      checkOutput("x64_ill", 64'(w_illegal_o), 64'd0);
      checkOutput("x64_tgt", w_target_o, wtgt[i]);
      e = refModel(winsn[i], 64'h1_0000_0000, 64);
      checkOutput("model64_imm", e.imm, wimm[i]);
      checkOutput("model64_fmt", 64'(e.fmt), 64'(wfmt[i]));
      checkOutput("model64_tgt", e.tgt, wtgt[i]);
    end
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
